// File: rtl/payload_unpack.sv
// payload_unpack: pulls the three payload bytes out of each newly validated
// 40-bit frame, queues them in a small show-ahead byte FIFO and streams them
// out over a valid/ready byte interface. Also counts accepted and dropped frames.
module payload_unpack #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_flag,
  input  logic [39:0]      valid_data_i,
  output logic [7:0]       m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             overflow,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [7:0]       drop_cnt
);

  localparam int AW = $clog2(DEPTH);

  // Highest fill level at which a whole 3-byte payload still fits.
  localparam logic [AW:0] MAX_FILL = (AW+1)'(DEPTH - 3);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CAP  = 2'd1;
  localparam logic [1:0] S_WR1  = 2'd2;
  localparam logic [1:0] S_WR2  = 2'd3;

  logic             validPrev_q;
  logic             newFrame;
  logic [1:0]       state_q, state_d;
  logic [15:0]      hold_q, hold_d;
  logic [AW:0]      wrPtr_q, rdPtr_q;
  logic [AW:0]      count;
  logic [7:0]       mem_q [DEPTH];
  logic [CNT_W-1:0] frameCnt_q;
  logic [7:0]       dropCnt_q;
  logic             push;
  logic [7:0]       pushData;
  logic             pop;
  logic             accept;
  logic             capDrop;
  logic             busyDrop;
  logic             hasSpace;

  // Header and checksum bytes are deliberately thrown away.
  logic unusedFrameBits;
  assign unusedFrameBits = ^{valid_data_i[39:32], valid_data_i[7:0]};

  // The validator holds valid_flag high for many cycles; only its rising edge marks a frame.
  assign newFrame = valid_flag & ~validPrev_q;

  assign count    = wrPtr_q - rdPtr_q;
  assign hasSpace = (count <= MAX_FILL);
  assign m_valid  = (count != '0);
  assign m_data   = mem_q[rdPtr_q[AW-1:0]];
  assign pop      = m_valid & m_ready;

  // A frame seen while a previous one is still being written cannot be taken.
  assign busyDrop = newFrame & (state_q != S_IDLE);
  assign overflow = capDrop | busyDrop;

  assign frame_cnt = frameCnt_q;
  assign drop_cnt  = dropCnt_q;

  // Frame sequencer: capture decision, then one byte written per cycle.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    push     = 1'b0;
    pushData = 8'h00;
    accept   = 1'b0;
    capDrop  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (newFrame) begin
          state_d = S_CAP;
        end
      end
      S_CAP: begin
        // Space is judged on the pre-pop count; a same-cycle pop only adds room.
        if (hasSpace) begin
          push     = 1'b1;
          pushData = valid_data_i[31:24];
          hold_d   = valid_data_i[23:8];
          accept   = 1'b1;
          state_d  = S_WR1;
        end else begin
          capDrop = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WR1: begin
        push     = 1'b1;
        pushData = hold_q[15:8];
        state_d  = S_WR2;
      end
      S_WR2: begin
        push     = 1'b1;
        pushData = hold_q[7:0];
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer state, edge-detect history and payload holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      validPrev_q <= 1'b0;
      hold_q      <= 16'h0000;
    end else begin
      state_q     <= state_d;
      validPrev_q <= valid_flag;
      hold_q      <= hold_d;
    end
  end

  // FIFO pointers; push and pop may both happen in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (push) begin
        wrPtr_q <= wrPtr_q + (AW+1)'(1);
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + (AW+1)'(1);
      end
    end
  end

  // FIFO storage is left unreset; m_valid masks any stale contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q[AW-1:0]] <= pushData;
    end
  end

  // Frame statistics: accepted count wraps, dropped count sticks at 255.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frameCnt_q <= '0;
      dropCnt_q  <= 8'h00;
    end else begin
      if (accept) begin
        frameCnt_q <= frameCnt_q + CNT_W'(1);
      end
      if (overflow && (dropCnt_q != 8'hFF)) begin
        dropCnt_q <= dropCnt_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_payload_unpack.sv
// tb_payload_unpack: directed stimulus for payload_unpack, checked every cycle
// against a queue-based byte/frame model plus hand-computed literal values.
module tb_payload_unpack;

  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             valid_flag = 1'b0;
  logic [39:0]      valid_data_i = 40'h0;
  logic [7:0]       m_data;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic             overflow;
  logic [CNT_W-1:0] frame_cnt;
  logic [7:0]       drop_cnt;

  logic [39:0]      nextFrame = 40'h0;
  int               checks = 0;
  int               errors = 0;
  int               ovfSeen = 0;
  logic [7:0]       gotBytes[$];

  // Model state
  logic [7:0]       expQ[$];
  logic [7:0]       pendQ[$];
  bit               capFlag = 1'b0;
  bit               mPrev = 1'b0;
  int               expFrames = 0;
  int               expDrops = 0;

  payload_unpack #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .valid_flag(valid_flag),
    .valid_data_i(valid_data_i),
    .m_data(m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .overflow(overflow),
    .frame_cnt(frame_cnt),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Upstream validator register: loads the frame on edges where the flag is high.
  always @(posedge clk) begin
    if (valid_flag) valid_data_i <= nextFrame;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic dropOne();
    if (expDrops < 255) expDrops++;
  endtask

  // Model advances one clock: pop, deliver bytes, take accept/drop decisions.
  task automatic modelStep();
    bit nf;
    bit busy;
    int sizeBefore;
    if (rst) begin
      expQ.delete();
      pendQ.delete();
      capFlag = 1'b0;
      mPrev = 1'b0;
      expFrames = 0;
      expDrops = 0;
      return;
    end
    nf = valid_flag && !mPrev;
    busy = capFlag || (pendQ.size() != 0);
    sizeBefore = expQ.size();
    if (sizeBefore != 0 && m_ready) void'(expQ.pop_front());
    if (capFlag) begin
      if (DEPTH - sizeBefore >= 3) begin
        expQ.push_back(valid_data_i[31:24]);
        pendQ.push_back(valid_data_i[23:16]);
        pendQ.push_back(valid_data_i[15:8]);
        expFrames++;
      end else begin
        dropOne();
      end
    end else if (pendQ.size() != 0) begin
      expQ.push_back(pendQ.pop_front());
    end
    if (nf && busy) dropOne();
    capFlag = nf && !busy;
    mPrev = valid_flag;
  endtask

  always @(posedge clk or posedge rst) modelStep();

  // Compare every output against the model mid-cycle.
  task automatic compareStep();
    bit nf;
    bit busy;
    bit expOvf;
    nf = valid_flag && !mPrev;
    busy = capFlag || (pendQ.size() != 0);
    expOvf = (capFlag && (DEPTH - expQ.size() < 3)) || (nf && busy);
    checkOutput("m_valid", m_valid, 32'(expQ.size() != 0));
    if (expQ.size() != 0) checkOutput("m_data", m_data, expQ[0]);
    checkOutput("overflow", overflow, 32'(expOvf));
    checkOutput("frame_cnt", frame_cnt, 32'(expFrames % 65536));
    checkOutput("drop_cnt", drop_cnt, 32'(expDrops));
    if (expQ.size() > DEPTH) checkOutput("model_fill", expQ.size(), DEPTH);
    if (overflow) ovfSeen++;
    if (m_valid && m_ready) gotBytes.push_back(m_data);
  endtask

  always @(negedge clk) begin
    if (!rst) compareStep();
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    @(posedge clk);
    #1;
    rst = 1'b1;
    valid_flag = 1'b0;
    m_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic applyStimulus(input logic [39:0] frame, input int highCycles, input int lowCycles);
    nextFrame = frame;
    valid_flag = 1'b1;
    repeat (highCycles) step();
    valid_flag = 1'b0;
    repeat (lowCycles) step();
  endtask

  task automatic checkByteAt(input string name, input int idx, input logic [7:0] expected);
    if (idx < gotBytes.size()) checkOutput(name, gotBytes[idx], expected);
    else checkOutput(name, 32'hDEAD, expected);
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin : main
    int base;
    int ovfBase;
    logic [7:0] drainExp[7];

    // Reset state
    #2;
    checkOutput("reset_m_valid", m_valid, 0);
    checkOutput("reset_frame_cnt", frame_cnt, 0);
    checkOutput("reset_drop_cnt", drop_cnt, 0);
    checkOutput("reset_overflow", overflow, 0);
    resetDut();

    // Single frame, long valid level
    ovfBase = ovfSeen;
    base = gotBytes.size();
    m_ready = 1'b1;
    nextFrame = 40'hCC_12_34_56_68;
    valid_flag = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("single_b0_valid", m_valid, 1);
    checkOutput("single_b0", m_data, 8'h12);
    @(negedge clk);
    checkOutput("single_b1", m_data, 8'h34);
    @(negedge clk);
    checkOutput("single_b2", m_data, 8'h56);
    @(negedge clk);
    checkOutput("single_empty", m_valid, 0);
    repeat (5) @(posedge clk);
    #1;
    valid_flag = 1'b0;
    repeat (6) step();
    checkOutput("single_frame_cnt", frame_cnt, 1);
    checkOutput("single_drop_cnt", drop_cnt, 0);
    checkOutput("single_ovf", ovfSeen - ovfBase, 0);
    checkOutput("single_nbytes", gotBytes.size() - base, 3);

    // Backpressure fill
    resetDut();
    ovfBase = ovfSeen;
    applyStimulus(40'hA1_01_02_03_5A, 2, 4);
    applyStimulus(40'hA2_04_05_06_5A, 2, 4);
    applyStimulus(40'hA3_07_08_09_5A, 2, 4);
    checkOutput("bp_frame_cnt", frame_cnt, 2);
    checkOutput("bp_drop_cnt", drop_cnt, 1);
    checkOutput("bp_ovf", ovfSeen - ovfBase, 1);
    base = gotBytes.size();
    m_ready = 1'b1;
    repeat (10) step();
    checkOutput("bp_nbytes", gotBytes.size() - base, 6);
    for (int i = 0; i < 6; i++) checkByteAt("bp_byte", base + i, 8'(i + 1));

    // Concurrent pop during capture
    resetDut();
    applyStimulus(40'hA1_01_02_03_5A, 2, 4);
    applyStimulus(40'hA2_04_05_06_5A, 2, 4);
    nextFrame = 40'hA3_07_08_09_5A;
    valid_flag = 1'b1;
    step();
    valid_flag = 1'b0;
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    repeat (3) step();
    checkOutput("cp6_drop_cnt", drop_cnt, 1);
    checkOutput("cp6_frame_cnt", frame_cnt, 2);
    nextFrame = 40'hA4_0A_0B_0C_00;
    valid_flag = 1'b1;
    step();
    valid_flag = 1'b0;
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    repeat (3) step();
    checkOutput("cp5_drop_cnt", drop_cnt, 1);
    checkOutput("cp5_frame_cnt", frame_cnt, 3);
    base = gotBytes.size();
    m_ready = 1'b1;
    repeat (12) step();
    drainExp = '{8'h03, 8'h04, 8'h05, 8'h06, 8'h0A, 8'h0B, 8'h0C};
    checkOutput("cp_nbytes", gotBytes.size() - base, 7);
    for (int i = 0; i < 7; i++) checkByteAt("cp_byte", base + i, drainExp[i]);

    // New frame while writing the previous one
    resetDut();
    ovfBase = ovfSeen;
    m_ready = 1'b1;
    base = gotBytes.size();
    nextFrame = 40'hA5_11_22_33_00;
    valid_flag = 1'b1;
    step();
    valid_flag = 1'b0;
    step();
    nextFrame = 40'hA6_44_55_66_00;
    valid_flag = 1'b1;
    step();
    valid_flag = 1'b0;
    repeat (6) step();
    checkOutput("wr1_frame_cnt", frame_cnt, 1);
    checkOutput("wr1_drop_cnt", drop_cnt, 1);
    checkOutput("wr1_ovf", ovfSeen - ovfBase, 1);
    checkOutput("wr1_nbytes", gotBytes.size() - base, 3);
    checkByteAt("wr1_b0", base, 8'h11);
    checkByteAt("wr1_b1", base + 1, 8'h22);
    checkByteAt("wr1_b2", base + 2, 8'h33);

    // Reset in the middle of a frame
    resetDut();
    nextFrame = 40'hA7_77_88_99_00;
    valid_flag = 1'b1;
    step();
    valid_flag = 1'b0;
    step();
    checkOutput("prerst_m_valid", m_valid, 1);
    checkOutput("prerst_frame_cnt", frame_cnt, 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_m_valid", m_valid, 0);
    checkOutput("rst_frame_cnt", frame_cnt, 0);
    checkOutput("rst_drop_cnt", drop_cnt, 0);
    checkOutput("rst_overflow", overflow, 0);
    step();
    rst = 1'b0;
    step();
    base = gotBytes.size();
    m_ready = 1'b1;
    applyStimulus(40'hA8_AA_BB_CC_00, 2, 6);
    checkOutput("postrst_nbytes", gotBytes.size() - base, 3);
    checkByteAt("postrst_b0", base, 8'hAA);
    checkByteAt("postrst_b1", base + 1, 8'hBB);
    checkByteAt("postrst_b2", base + 2, 8'hCC);
    checkOutput("postrst_frame_cnt", frame_cnt, 1);

    // Drop counter saturation
    resetDut();
    applyStimulus(40'hA1_01_02_03_5A, 2, 4);
    applyStimulus(40'hA2_04_05_06_5A, 2, 4);
    for (int i = 0; i < 300; i++) applyStimulus(40'hB0_00_00_00_00 | 40'(i), 1, 3);
    checkOutput("sat_drop_cnt", drop_cnt, 255);
    checkOutput("sat_frame_cnt", frame_cnt, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
